// File: rtl/receive_pixel.sv
// UART receiver that turns two-byte frames into 12-bit pixels on a valid/ready output.
// Define RECEIVE_PIXEL_TIMEOUT_EN to drop a stale high byte after TIMEOUT_BITS idle bit periods.
module receive_pixel #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_TYPE  = 0,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_in,
  input  logic        ready_in,
  output logic [11:0] pixel_out,
  output logic        valid_out,
  output logic        parity_err,
  output logic        frame_err,
  output logic        sync_err,
  output logic        overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic PAR_ODD  = (PARITY_TYPE == 1);
  localparam logic PAR_NONE = (PARITY_TYPE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} bit_state_e;
  typedef enum logic {WAIT_HIGH, WAIT_LOW} pair_state_e;

  logic             sync1_q, sync2_q, prev_q;
  bit_state_e       bst_q;
  pair_state_e      pst_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bidx_q;
  logic [7:0]       data_q;
  logic [7:0]       high_q;
  logic             par_bad_q;

  logic fall, tick_half, tick_bit, stop_smp;
  logic byte_ok, frm_bad, par_fail, line_err, low_ok, new_pix, tmo_hit;

  always_comb begin
    fall      = prev_q & ~sync2_q;
    tick_half = (cnt_q == HALF_LAST);
    tick_bit  = (cnt_q == BIT_LAST);
    stop_smp  = (bst_q == STOP) && tick_bit;
    // A bad stop bit masks a parity failure so only one error pulses per byte.
    byte_ok   = stop_smp && sync2_q && !par_bad_q;
    frm_bad   = stop_smp && !sync2_q;
    par_fail  = stop_smp && sync2_q && par_bad_q;
    line_err  = frm_bad || par_fail;
    low_ok    = (data_q[7:4] == 4'h0);
    new_pix   = (pst_q == WAIT_LOW) && byte_ok && low_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      bst_q      <= IDLE;
      cnt_q      <= '0;
      bidx_q     <= '0;
      data_q     <= '0;
      par_bad_q  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync1_q    <= uart_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      frame_err  <= frm_bad;
      parity_err <= par_fail;
      case (bst_q)
        IDLE: begin
          cnt_q <= '0;
          if (fall) begin
            bst_q     <= START;
            par_bad_q <= 1'b0;
          end
        end
        START: begin
          if (tick_half) begin
            cnt_q  <= '0;
            bidx_q <= '0;
            bst_q  <= sync2_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_bit) begin
            cnt_q  <= '0;
            data_q <= {sync2_q, data_q[7:1]};
            bidx_q <= bidx_q + 1'b1;
            if (bidx_q == 3'd7) bst_q <= PAR_NONE ? STOP : PARITY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_bit) begin
            cnt_q     <= '0;
            par_bad_q <= (^data_q) ^ sync2_q ^ PAR_ODD;
            bst_q     <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_bit) begin
            cnt_q <= '0;
            bst_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: bst_q <= IDLE;
      endcase
    end
  end

`ifdef RECEIVE_PIXEL_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [31:0] tmo_q;

  // Leaving WAIT_LOW holds the counter at zero, so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst || pst_q != WAIT_LOW || fall) tmo_q <= '0;
    else if (bst_q == IDLE) tmo_q <= tmo_q + 1'b1;
  end

  always_comb tmo_hit = (pst_q == WAIT_LOW) && (bst_q == IDLE) && !fall && (tmo_q == TMO_LAST);
`else
  always_comb tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pst_q     <= WAIT_HIGH;
      high_q    <= '0;
      pixel_out <= '0;
      valid_out <= 1'b0;
      sync_err  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync_err <= (pst_q == WAIT_LOW) && byte_ok && !low_ok;
      overrun  <= new_pix && valid_out && !ready_in;
      if (line_err) begin
        pst_q <= WAIT_HIGH;
      end else if (byte_ok) begin
        if (pst_q == WAIT_HIGH || !low_ok) begin
          high_q <= data_q;
          pst_q  <= WAIT_LOW;
        end else begin
          pst_q <= WAIT_HIGH;
        end
      end else if (tmo_hit) begin
        pst_q <= WAIT_HIGH;
      end
      if (new_pix && (!valid_out || ready_in)) begin
        pixel_out <= {high_q, data_q[3:0]};
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receive_pixel.sv
// Scoreboard bench for receive_pixel: directed UART frames, monitor pops expected pixels on handshake.
module tb_receive_pixel;
  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_in = 1'b1;
  logic        ready_in = 1'b1;
  logic [11:0] pixel_out;
  logic        valid_out, parity_err, frame_err, sync_err, overrun;

  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];
  int n_par = 0, n_frm = 0, n_syn = 0, n_ovr = 0;
  int e_par = 0, e_frm = 0, e_syn = 0, e_ovr = 0;
  logic        hold_q = 1'b0;
  logic [11:0] held_pix = '0;

  receive_pixel #(.CLKS_PER_BIT(CPB), .PARITY_TYPE(0), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in), .ready_in(ready_in),
    .pixel_out(pixel_out), .valid_out(valid_out), .parity_err(parity_err),
    .frame_err(frame_err), .sync_err(sync_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v);
    uart_in = v;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    line(1'b0);
    for (int i = 0; i < 8; i++) line(b[i]);
    line((^b) ^ bad_par);
    line(!bad_stop);
    uart_in = 1'b1;
    tick(CPB);
  endtask

  task automatic check_errs(input string tag);
    tick(2 * CPB);
    check({tag, " parity_err count"}, n_par, e_par);
    check({tag, " frame_err count"}, n_frm, e_frm);
    check({tag, " sync_err count"}, n_syn, e_syn);
    check({tag, " overrun count"}, n_ovr, e_ovr);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (parity_err) n_par++;
      if (frame_err) n_frm++;
      if (sync_err) n_syn++;
      if (overrun) n_ovr++;
      if (hold_q) begin
        check("held valid_out", int'(valid_out), 1);
        check("held pixel_out", int'(pixel_out), int'(held_pix));
      end
      hold_q = valid_out && !ready_in;
      held_pix = pixel_out;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) check("unexpected pixel", int'(pixel_out), -1);
        else check("pixel_out", int'(pixel_out), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset valid_out", int'(valid_out), 0);
    check("reset pixel_out", int'(pixel_out), 0);
    check("reset error pulses", int'({parity_err, frame_err, sync_err, overrun}), 0);
    tick(CPB);

    exp_q.push_back(12'hABC);
    send_byte(8'hAB, 1'b0, 1'b0);
    send_byte(8'h0C, 1'b0, 1'b0);
    check_errs("basic");

    exp_q.push_back(12'h123);
    e_par++;
    send_byte(8'hAB, 1'b0, 1'b0);
    send_byte(8'h0C, 1'b1, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    check_errs("parity");

    exp_q.push_back(12'h345);
    e_syn++;
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    check_errs("resync");

    ready_in = 1'b0;
    exp_q.push_back(12'h111);
    e_ovr++;
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    check_errs("overrun");
    check("stalled valid_out", int'(valid_out), 1);
    check("stalled pixel_out", int'(pixel_out), 12'h111);
    ready_in = 1'b1;
    tick(3);
    check("drained valid_out", int'(valid_out), 0);
    check("drained queue", exp_q.size(), 0);

    // Stored high byte, short glitch, then reset mid-byte must leave nothing behind.
    send_byte(8'h0F, 1'b0, 1'b0);
    uart_in = 1'b0;
    tick(CPB / 2 - 4);
    uart_in = 1'b1;
    tick(2 * CPB);
    line(1'b0);
    for (int i = 0; i < 3; i++) line(1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2 * CPB);
    exp_q.push_back(12'h0A5);
    send_byte(8'h0A, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    check_errs("glitch/reset");

`ifdef RECEIVE_PIXEL_TIMEOUT_EN
    exp_q.push_back(12'h012);
`else
    exp_q.push_back(12'h7F1);
`endif
    send_byte(8'h7F, 1'b0, 1'b0);
    tick(25 * CPB);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    check_errs("timeout");

    e_frm += 2;
    exp_q.push_back(12'h034);
    send_byte(8'h55, 1'b0, 1'b1);
    send_byte(8'h66, 1'b1, 1'b1);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    check_errs("framing");

    check("final queue empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
